// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, issues requests
// to a variable-latency instruction memory, squashes responses from a
// redirected path, holds one response while decode stalls, and stops after HALT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        take_new_PC,
    input  logic [15:0] new_PC,
    input  logic        stall,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] PC_inc,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_inc;
    logic        r_valid;
    logic [15:0] r_buf_data;
    logic [15:0] r_buf_pc;
    logic        r_buf_full;
    logic        r_err;

    logic        w_gate;
    logic        w_rd;
    logic        w_accept;
    logic        w_consume;
    logic        w_is_halt;
    logic        w_pending;
    logic        w_err_nxt;
    logic [15:0] w_pc_plus2;

    // A new request would have nowhere to land while the buffer is full or
    // while decode is stalled on a valid instruction.
    assign w_gate     = r_buf_full || (stall && r_valid);
    assign w_rd       = (r_state == S_REQ) && !w_gate;
    assign w_accept   = w_rd && !imem_stall;
    assign w_consume  = !take_new_PC && imem_done &&
                        (((r_state == S_REQ) && w_accept) || (r_state == S_WAIT));
    assign w_is_halt  = (imem_data[15:11] == HALT_OPC);
    assign w_pc_plus2 = r_pc + 16'd2;

    // A request is still in flight after this cycle when memory has it but
    // has not answered yet; a redirect must then squash that late answer.
    assign w_pending  = !imem_done &&
                        ((r_state == S_WAIT) || (r_state == S_DROP) ||
                         ((r_state == S_REQ) && w_accept));

    assign w_err_nxt  = (take_new_PC && new_PC[0]) ||
                        (imem_done && ((r_state == S_HALT) ||
                                       ((r_state == S_REQ) && !w_accept)));

    assign imem_addr   = r_pc;
    assign imem_rd     = w_rd;
    assign instr       = r_instr;
    assign PC_inc      = r_pc_inc;
    assign instr_valid = r_valid;
    assign halted      = (r_state == S_HALT);
    assign err         = r_err;

    // Next fetch state; a redirect overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        if (take_new_PC) begin
            w_state_nxt = w_pending ? S_DROP : S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        if (imem_done) w_state_nxt = w_is_halt ? S_HALT : S_REQ;
                        else           w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_done) w_state_nxt = w_is_halt ? S_HALT : S_REQ;
                end
                S_DROP: begin
                    if (imem_done) w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_HALT;
            endcase
        end
    end

    // Control state: FSM, PC, error pulse and buffer occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_err      <= 1'b0;
            r_buf_full <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (take_new_PC) begin
                r_pc       <= {new_PC[15:1], 1'b0};
                r_buf_full <= 1'b0;
            end else if (w_consume) begin
                r_pc <= w_pc_plus2;
                if (stall) r_buf_full <= 1'b1;
            end else if (!stall && r_buf_full) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    // IF/ID register: squash on redirect, load a fresh or buffered word when
    // decode advances, empty the slot when decode advances with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr  <= NOP_INSTR;
            r_pc_inc <= RESET_PC;
            r_valid  <= 1'b0;
        end else if (take_new_PC) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_consume && !stall) begin
            r_instr  <= imem_data;
            r_pc_inc <= w_pc_plus2;
            r_valid  <= 1'b1;
        end else if (!stall && r_buf_full) begin
            r_instr  <= r_buf_data;
            r_pc_inc <= r_buf_pc;
            r_valid  <= 1'b1;
        end else if (!stall) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    // Skid buffer payload; its occupancy flag alone says whether it is live.
    always_ff @(posedge clk) begin
        if (w_consume && stall) begin
            r_buf_data <= imem_data;
            r_buf_pc   <= w_pc_plus2;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [4:0]  HALT     = 5'b00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        take_new_PC = 1'b0;
    logic [15:0] new_PC = 16'h0;
    logic        stall = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic        imem_stall = 1'b0;
    logic        imem_done = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic [15:0] instr;
    logic [15:0] PC_inc;
    logic        instr_valid;
    logic        halted;
    logic        err;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP), .HALT_OPC(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .take_new_PC(take_new_PC), .new_PC(new_PC),
        .stall(stall), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_stall(imem_stall), .imem_done(imem_done), .imem_data(imem_data),
        .instr(instr), .PC_inc(PC_inc), .instr_valid(instr_valid),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: PC, IF/ID contents, a queue for the skid buffer,
    // and flags for "request in flight" / "that request is squashed".
    logic [15:0] m_pc, m_instr, m_pcinc;
    bit          m_valid, m_halted, m_out, m_squash, m_err;
    logic [31:0] m_buf[$];

    // Test-side memory: one outstanding request with a countdown.
    bit          mem_pending;
    int          mem_cnt;
    logic [15:0] mem_data;

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = NOP; m_pcinc = RESET_PC;
        m_valid = 0; m_halted = 0; m_out = 0; m_squash = 0; m_err = 0;
        m_buf.delete();
        mem_pending = 0; mem_cnt = 0; mem_data = 16'h0;
    endtask

    function automatic bit m_rd();
        return !m_halted && !m_out && (m_buf.size() == 0) && !(stall && m_valid);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("imem_rd",     {15'd0, imem_rd},     {15'd0, m_rd()});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("instr",       instr,                m_instr);
        chk("PC_inc",      PC_inc,               m_pcinc);
        chk("instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
        chk("halted",      {15'd0, halted},      {15'd0, m_halted});
        chk("err",         {15'd0, err},         {15'd0, m_err});
    endtask

    task automatic model_update();
        bit          acc, got, was_squash;
        logic [15:0] nxt;
        acc = m_rd() && !imem_stall;
        got = 0;
        m_err = (take_new_PC && new_PC[0]) ||
                (imem_done && (m_halted || (!m_out && !acc)));
        if (take_new_PC) begin
            m_out    = (m_out || acc) && !imem_done;
            m_squash = m_out;
            m_pc     = {new_PC[15:1], 1'b0};
            m_instr  = NOP;
            m_valid  = 0;
            m_buf.delete();
            m_halted = 0;
        end else begin
            if (imem_done && (acc || m_out)) begin
                was_squash = m_out && m_squash;
                m_out = 0; m_squash = 0;
                got = !was_squash;
            end else if (acc) begin
                m_out = 1; m_squash = 0;
            end
            if (got) begin
                nxt = m_pc + 16'd2;
                if (imem_data[15:11] == HALT) m_halted = 1;
                m_pc = nxt;
                if (!stall) begin
                    m_instr = imem_data; m_pcinc = nxt; m_valid = 1;
                end else begin
                    m_buf.push_back({nxt, imem_data});
                end
            end else if (!stall && m_buf.size() != 0) begin
                m_pcinc = m_buf[0][31:16];
                m_instr = m_buf[0][15:0];
                m_valid = 1;
                m_buf.delete();
            end else if (!stall) begin
                m_instr = NOP; m_valid = 0;
            end
        end
    endtask

    // One cycle: apply inputs after the falling edge, check, advance model.
    task automatic step(input bit s, input bit t, input logic [15:0] np,
                        input bit is, input bit d, input logic [15:0] dat);
        stall = s; take_new_PC = t; new_PC = np;
        imem_stall = is; imem_done = d; imem_data = dat;
        #1;
        compare();
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 24) == 0) w[15:11] = HALT;
        else if (w[15:11] == HALT) w[15:11] = 5'h1F;
        return w;
    endfunction

    task automatic rstep();
        bit          s, t, is, d, acc;
        logic [15:0] np, dat;
        int          lat;
        s  = ($urandom_range(0, 3) == 0);
        t  = ($urandom_range(0, 11) == 0);
        np = 16'($urandom);
        if ($urandom_range(0, 3) != 0) np[0] = 1'b0;
        is = ($urandom_range(0, 3) == 0);
        stall = s;
        acc = m_rd() && !is;
        lat = $urandom_range(0, 3);
        d = 0;
        dat = 16'($urandom);
        if (mem_pending && mem_cnt == 0) begin
            d = 1; dat = mem_data;
        end else if (!mem_pending && acc && lat == 0) begin
            d = 1; dat = gen_word();
        end else if (!mem_pending && !acc && $urandom_range(0, 39) == 0) begin
            d = 1;
        end
        if (mem_pending) begin
            if (d) mem_pending = 0;
            else   mem_cnt--;
        end else if (acc && !d) begin
            mem_pending = 1; mem_cnt = lat - 1; mem_data = gen_word();
        end
        step(s, t, np, is, d, dat);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst instr",  instr, NOP);
        chk("rst PC_inc", PC_inc, RESET_PC);
        chk("rst valid",  {15'd0, instr_valid}, 16'd0);
        chk("rst addr",   imem_addr, RESET_PC);
        chk("rst err",    {15'd0, err}, 16'd0);
        rst_n = 1'b1;

        // Zero-wait stream
        chk("first rd", {15'd0, imem_rd}, 16'd1);
        step(0, 0, 0, 0, 1, 16'h4001);
        chk("z1 instr", instr, 16'h4001); chk("z1 pcinc", PC_inc, 16'h0002);
        chk("z1 addr", imem_addr, 16'h0002);
        step(0, 0, 0, 0, 1, 16'h4002);
        chk("z2 instr", instr, 16'h4002); chk("z2 pcinc", PC_inc, 16'h0004);
        step(0, 0, 0, 0, 1, 16'h4003);
        chk("z3 instr", instr, 16'h4003); chk("z3 pcinc", PC_inc, 16'h0006);

        // 3-cycle latency with redirect one cycle after acceptance
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 16'h0100, 0, 0, 0);
        chk("redir valid", {15'd0, instr_valid}, 16'd0);
        chk("drop rd", {15'd0, imem_rd}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 16'h4444);
        chk("post-drop addr", imem_addr, 16'h0100);
        chk("post-drop instr", instr, NOP);
        step(0, 0, 0, 0, 1, 16'h4005);
        chk("redir instr", instr, 16'h4005); chk("redir pcinc", PC_inc, 16'h0102);

        // Stall while a response for 0x0010 is pending
        step(0, 1, 16'h000E, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h1111);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 16'h5A5A);
        chk("stall instr", instr, NOP); chk("stall pcinc", PC_inc, 16'h0010);
        chk("stall rd", {15'd0, imem_rd}, 16'd0);
        step(1, 0, 0, 0, 0, 0);
        chk("stall rd2", {15'd0, imem_rd}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("drain instr", instr, 16'h5A5A); chk("drain pcinc", PC_inc, 16'h0012);
        chk("drain rd", {15'd0, imem_rd}, 16'd1);

        // HALT at 0x0020, idle, error on stray response, then restart
        step(0, 1, 16'h0020, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0000);
        chk("halted", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("halt rd", {15'd0, imem_rd}, 16'd0);
        end
        step(0, 0, 0, 0, 1, 16'hBEEF);
        chk("halt err", {15'd0, err}, 16'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("halt err clr", {15'd0, err}, 16'd0);
        step(0, 1, 16'h0040, 0, 0, 0);
        chk("unhalt", {15'd0, halted}, 16'd0); chk("unhalt addr", imem_addr, 16'h0040);

        // Wrap-around and odd redirect target
        step(0, 1, 16'hFFFE, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h4000);
        chk("wrap addr", imem_addr, 16'h0000); chk("wrap pcinc", PC_inc, 16'h0000);
        step(0, 1, 16'h0033, 1, 0, 0);
        chk("odd err", {15'd0, err}, 16'd1); chk("odd addr", imem_addr, 16'h0032);
        step(0, 0, 0, 1, 0, 0);
        chk("odd err clr", {15'd0, err}, 16'd0);

        // Asynchronous reset during WAIT
        step(0, 0, 0, 0, 0, 0);
        stall = 0; take_new_PC = 0; imem_stall = 1; imem_done = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst instr", instr, NOP); chk("arst valid", {15'd0, instr_valid}, 16'd0);
        chk("arst addr", imem_addr, RESET_PC); chk("arst pcinc", PC_inc, RESET_PC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst rd", {15'd0, imem_rd}, 16'd1);
        step(0, 0, 0, 1, 1, 16'h1234);
        chk("stale err", {15'd0, err}, 16'd1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) rstep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
